alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational RV32 ALU between two requesters, e.g. requester 0 = execute stage and requester 1 = multi-cycle address/branch helper.
- Uses round-robin arbitration with a valid/ready handshake on both the request and response sides.
- Drives the ALU operands from the winning requester and registers the result, flags and requester ID into a one-entry response buffer.
- Sits between the requesters and the ALU instance; the ALU itself is instantiated outside this block.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CNTW, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant/accept; one-hot or zero.
- req_a  in  2xWIDTH  operand a per requester.
- req_b  in  2xWIDTH  operand b per requester.
- req_ctrl  in  2x4  alucontrol per requester.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_ctrl  out  4  to ALU alucontrol.
- alu_result  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.
- alu_lt  in  1  from ALU.
- rsp_valid  out  1  response buffer full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  registered ALU result.
- rsp_zero  out  1  registered zero flag.
- rsp_lt  out  1  registered lt flag.
- rsp_illegal  out  1  request carried an undefined alucontrol.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_lt=0, rsp_illegal=0, last_grant=1 (requester 0 wins first), counters=0.
- can_accept = ~rsp_valid | rsp_ready. This is combinational and allows full throughput when the consumer holds rsp_ready=1.
- Grant, computed combinationally:
  - Only when can_accept.
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - req_ready = grant. No grant when can_accept=0.
- req_ready must not depend on req_a, req_b or req_ctrl.
- A request transfer occurs on req_valid[i] & req_ready[i].
- ALU mux:
  - alu_a, alu_b and alu_ctrl come from the granted requester.
  - With no grant they come from requester 0's inputs; the result is ignored.
  - The mux is purely combinational; ALU settling fits in one cycle.
- On a transfer edge:
  - Capture the ALU outputs into the response registers.
  - rsp_id = granted index; last_grant = granted index; rsp_valid = 1.
- Illegal control: if req_ctrl > 4'b1011, capture rsp_result=0, rsp_zero=0, rsp_lt=0, rsp_illegal=1. Otherwise rsp_illegal=0.
- Response handshake:
  - rsp_valid & rsp_ready with no new transfer: rsp_valid returns to 0 and the data registers hold their value.
  - The same edge drained and refilled: rsp_valid stays 1 and the new data loads.
- Latency: accept in cycle N, rsp_valid=1 in cycle N+1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, req_ready=0, response outputs are stable, and last_grant does not change.
- Starvation bound: a requester held valid is granted within 2 accept opportunities.
- Requesters may drop req_valid without a grant; no state change results.
- Reset mid-operation: any buffered response is discarded and no partial state is retained.
- Two-state FSM on rsp_valid:
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY on drain with no transfer.
  - FULL -> FULL on drain plus transfer, or on stall.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (CNTW each) and stall_cnt (CNTW).
  - Each grant counter increments on that requester's transfer.
  - stall_cnt increments on each cycle with any req_valid high and no grant.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - alucontrol localparams ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLT=5, ALU_SLLI=6, ALU_SRLI=7, ALU_SRAI=8, ALU_SLL=9, ALU_SRL=10, ALU_SRA=11.
  - ALU_CTRL_MAX=4'b1011.
  - A typedef alu_req_t bundling a, b and ctrl.
- One sub-module rr_arb2: inputs req[1:0], en, last; output grant[1:0]. It is a pure combinational round-robin decision; the last_grant register stays in the top level.

Test Plan:
- Single request: req0 a=5, b=3, ctrl=ADD, rsp_ready=1 → req_ready=01 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
- Contention after reset: both valid, req0 ctrl=SUB a=b=7, req1 ctrl=SLT a=-1, b=1, both held → grants 0 then 1. Responses are (id0, result 0, zero=1) then (id1, result 1, lt=1).
- Backpressure: rsp_ready=0 for 3 cycles with a full buffer → req_ready=00 and response outputs unchanged. Raising rsp_ready gives a drain and an accept on the same edge, with rsp_valid held at 1.
- Illegal control: req1 ctrl=4'b1100 → rsp_illegal=1, rsp_result=0, rsp_id=1. The next legal request gives rsp_illegal=0.
- Reset mid-operation: assert reset_n=0 asynchronously with rsp_valid=1 → all response outputs 0 immediately. After release, both valid → requester 0 is granted first.
- ALU_ARB_STATS_EN: 10 back-to-back requests alternating between requesters, plus 2 stall cycles → grant_cnt0=5, grant_cnt1=5, stall_cnt=2. With CNTW=2 forced, counters saturate at 3.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg                                                            |
// | RV32 ALU control encodings and request bundle shared by arbiter.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLLI = 4'd6;
  localparam logic [3:0] ALU_SRLI = 4'd7;
  localparam logic [3:0] ALU_SRAI = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [3:0] ALU_CTRL_MAX = 4'b1011;
  localparam int         ALU_XLEN     = 32;

  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [3:0]          ctrl;
  } alu_req_t;

  function automatic logic ctrl_illegal(input logic [3:0] ctrl);
    return ctrl > ALU_CTRL_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2                                                            |
// | Two-way combinational round-robin decision; history kept by caller.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Contention goes to whoever was not served last.
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_arbiter                                                        |
// | Round-robin sharing of one external ALU between two requesters     |
// | with a one-entry registered response buffer.                       |
// | Optional statistics counters: define ALU_ARB_STATS_EN.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][3:0]       req_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_lt,
  output logic                  rsp_illegal
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0]       grant_cnt0,
  output logic [CNTW-1:0]       grant_cnt1,
  output logic [CNTW-1:0]       stall_cnt
`endif
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             r_state;
  logic             w_next;
  logic             r_last;
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_lt;
  logic             r_illegal;
  logic             w_can_accept;
  logic [1:0]       w_grant;
  logic             w_xfer;
  logic             w_sel;
  logic             w_illegal;

  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;

  rr_arb2 u_arb (
    .req   (req_valid),
    .en    (w_can_accept),
    .last  (r_last),
    .grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  // With no grant the select defaults to requester 0.
  assign w_sel     = w_grant[1];
  assign alu_a     = req_a[w_sel];
  assign alu_b     = req_b[w_sel];
  assign alu_ctrl  = req_ctrl[w_sel];
  assign w_illegal = ctrl_illegal(alu_ctrl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_next = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_xfer) w_next = ST_EMPTY;
      default:  w_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == ST_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_lt      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_xfer) begin
      r_last    <= w_sel;
      r_id      <= w_sel;
      r_illegal <= w_illegal;
      r_result  <= w_illegal ? '0 : alu_result;
      r_zero    <= w_illegal ? 1'b0 : alu_zero;
      r_lt      <= w_illegal ? 1'b0 : alu_lt;
    end
  end

  assign rsp_id      = r_id;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_lt      = r_lt;
  assign rsp_illegal = r_illegal;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNTW-1:0] C_CNT_ONE = CNTW'(1);

  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;
  logic [CNTW-1:0] r_stall;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_grant[0] && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + C_CNT_ONE;
      if (w_grant[1] && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + C_CNT_ONE;
      if ((|req_valid) && !w_xfer && (r_stall != '1)) r_stall <= r_stall + C_CNT_ONE;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
  assign stall_cnt  = r_stall;
`else
  logic [CNTW-1:0] w_unused_cntw;
  assign w_unused_cntw = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_arbiter                                                     |
// | Randomized bench for alu_arbiter with a behavioural reference.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_arbiter;
  import alu_pkg::*;

  logic             clk;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_ctrl;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_ctrl;
  logic             alu_zero, alu_lt;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_lt, rsp_illegal;
  logic [31:0]      rsp_result;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference ALU behaviour, also used as the stand-in for the external ALU.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'd0:        return a + b;
      4'd1:        return a - b;
      4'd2:        return a & b;
      4'd3:        return a | b;
      4'd4:        return a ^ b;
      4'd5:        return {31'b0, $signed(a) < $signed(b)};
      4'd6, 4'd9:  return a << b[4:0];
      4'd7, 4'd10: return a >> b[4:0];
      4'd8, 4'd11: return $signed(a) >>> b[4:0];
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
    alu_lt     = $signed(alu_a) < $signed(alu_b);
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1, stc;
  logic [1:0]  gc0_s, gc1_s, stc_s;
  logic [1:0]  req_ready2;
  logic [31:0] alu_a2, alu_b2, alu_result2;
  logic [3:0]  alu_ctrl2;
  logic        alu_zero2, alu_lt2;
  logic        rsp_valid2, rsp_id2, rsp_zero2, rsp_lt2, rsp_illegal2;
  logic [31:0] rsp_result2;

  always_comb begin
    alu_result2 = alu_fn(alu_ctrl2, alu_a2, alu_b2);
    alu_zero2   = (alu_result2 == 32'd0);
    alu_lt2     = $signed(alu_a2) < $signed(alu_b2);
  end

  alu_arbiter #(.WIDTH(32), .CNTW(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2),
    .alu_result(alu_result2), .alu_zero(alu_zero2), .alu_lt(alu_lt2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
    .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .rsp_lt(rsp_lt2),
    .rsp_illegal(rsp_illegal2),
    .grant_cnt0(gc0_s), .grant_cnt1(gc1_s), .stall_cnt(stc_s)
  );
`endif

  alu_arbiter #(.WIDTH(32), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt),
    .rsp_illegal(rsp_illegal)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(gc0), .grant_cnt1(gc1), .stall_cnt(stc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input logic open, input int last);
    if (!open || v == 2'b00) return -1;
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Model state: the buffered response plus arbitration history and event counts.
  logic        m_valid = 1'b0;
  int          m_id = 0;
  int          m_last = 1;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0, m_lt = 1'b0, m_ill = 1'b0;
  longint      m_cnt0 = 0, m_cnt1 = 0, m_stall = 0;

  int          p_g = -1;
  logic        p_rdy = 1'b0, p_any = 1'b0;
  logic [31:0] p_res = '0;
  logic        p_zero = 1'b0, p_lt = 1'b0, p_ill = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 1'b0; m_id = 0; m_last = 1; m_res = '0;
      m_zero = 1'b0; m_lt = 1'b0; m_ill = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
    end else if (p_g >= 0) begin
      m_valid = 1'b1; m_id = p_g; m_last = p_g;
      m_res = p_res; m_zero = p_zero; m_lt = p_lt; m_ill = p_ill;
      if (p_g == 0) m_cnt0++; else m_cnt1++;
    end else begin
      if (m_valid && p_rdy) m_valid = 1'b0;
      if (p_any) m_stall++;
    end
  end

  always @(negedge clk) begin
    int g;
    int s;
    g = pick(req_valid, !m_valid || rsp_ready, m_last);
    s = (g < 0) ? 0 : g;
    check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : ((g == 0) ? 64'd1 : 64'd2));
    check("alu_a", 64'(alu_a), 64'(req_a[s]));
    check("alu_b", 64'(alu_b), 64'(req_b[s]));
    check("alu_ctrl", 64'(alu_ctrl), 64'(req_ctrl[s]));
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
    check("rsp_result", 64'(rsp_result), 64'(m_res));
    check("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    check("rsp_lt", 64'(rsp_lt), 64'(m_lt));
    check("rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
`ifdef ALU_ARB_STATS_EN
    check("grant_cnt0", 64'(gc0), sat(m_cnt0, 16));
    check("grant_cnt1", 64'(gc1), sat(m_cnt1, 16));
    check("stall_cnt", 64'(stc), sat(m_stall, 16));
    check("grant_cnt0_sat", 64'(gc0_s), sat(m_cnt0, 2));
    check("grant_cnt1_sat", 64'(gc1_s), sat(m_cnt1, 2));
    check("stall_cnt_sat", 64'(stc_s), sat(m_stall, 2));
`endif
    p_g   = g;
    p_rdy = rsp_ready;
    p_any = |req_valid;
    p_ill = req_ctrl[s] > 4'd11;
    p_res = p_ill ? 32'd0 : alu_fn(req_ctrl[s], req_a[s], req_b[s]);
    p_zero = !p_ill && (p_res == 32'd0);
    p_lt   = !p_ill && ($signed(req_a[s]) < $signed(req_b[s]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_ctrl = '0;
    repeat (2) tick();
    samp();
    check("lit_reset_valid", 64'(rsp_valid), 64'd0);
    check("lit_reset_result", 64'(rsp_result), 64'd0);
    tick();
    reset_n = 1'b1;

    // Single request.
    req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd3; req_ctrl[0] = ALU_ADD;
    rsp_ready = 1'b1;
    samp();
    check("lit_single_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    samp();
    check("lit_single_valid", 64'(rsp_valid), 64'd1);
    check("lit_single_id", 64'(rsp_id), 64'd0);
    check("lit_single_result", 64'(rsp_result), 64'd8);
    check("lit_single_zero", 64'(rsp_zero), 64'd0);

    // Contention right after reset.
    tick();
    do_reset();
    req_valid = 2'b11;
    req_ctrl[0] = ALU_SUB; req_a[0] = 32'd7; req_b[0] = 32'd7;
    req_ctrl[1] = ALU_SLT; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
    samp();
    check("lit_cont_g0", 64'(req_ready), 64'd1);
    tick();
    samp();
    check("lit_cont_id0", 64'(rsp_id), 64'd0);
    check("lit_cont_res0", 64'(rsp_result), 64'd0);
    check("lit_cont_zero0", 64'(rsp_zero), 64'd1);
    check("lit_cont_g1", 64'(req_ready), 64'd2);
    tick();
    samp();
    check("lit_cont_id1", 64'(rsp_id), 64'd1);
    check("lit_cont_res1", 64'(rsp_result), 64'd1);
    check("lit_cont_lt1", 64'(rsp_lt), 64'd1);

    // Backpressure: buffer holds the SUB response for three cycles.
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp();
      check("lit_bp_ready", 64'(req_ready), 64'd0);
      check("lit_bp_id", 64'(rsp_id), 64'd0);
      check("lit_bp_zero", 64'(rsp_zero), 64'd1);
      tick();
    end
    rsp_ready = 1'b1;
    samp();
    check("lit_bp_regrant", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    samp();
    check("lit_bp_valid", 64'(rsp_valid), 64'd1);
    check("lit_bp_id1", 64'(rsp_id), 64'd1);
    tick();

    // Illegal control followed by a legal request.
    req_valid = 2'b10; req_ctrl[1] = 4'hC; req_a[1] = 32'd123; req_b[1] = 32'd456;
    tick();
    req_valid = 2'b01; req_ctrl[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
    samp();
    check("lit_ill_flag", 64'(rsp_illegal), 64'd1);
    check("lit_ill_result", 64'(rsp_result), 64'd0);
    check("lit_ill_id", 64'(rsp_id), 64'd1);
    tick();
    req_valid = 2'b00;
    samp();
    check("lit_legal_flag", 64'(rsp_illegal), 64'd0);
    check("lit_legal_result", 64'(rsp_result), 64'd2);

    // Asynchronous reset with a full buffer.
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    check("lit_arst_valid", 64'(rsp_valid), 64'd0);
    check("lit_arst_result", 64'(rsp_result), 64'd0);
    check("lit_arst_flags", 64'({rsp_id, rsp_zero, rsp_lt, rsp_illegal}), 64'd0);
    tick();
    reset_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    samp();
    check("lit_arst_first", 64'(req_ready), 64'd1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int r = 0; r < 2; r++) begin
        req_a[r]    = $urandom;
        req_b[r]    = ($urandom_range(0, 3) == 0) ? req_a[r] : $urandom;
        req_ctrl[r] = 4'($urandom_range(0, 15));
      end
      tick();
    end

`ifdef ALU_ARB_STATS_EN
    do_reset();
    req_valid = 2'b11; rsp_ready = 1'b1;
    repeat (10) tick();
    rsp_ready = 1'b0;
    repeat (2) tick();
    req_valid = 2'b00;
    samp();
    check("lit_stats_cnt0", 64'(gc0), 64'd5);
    check("lit_stats_cnt1", 64'(gc1), 64'd5);
    check("lit_stats_stall", 64'(stc), 64'd2);
    check("lit_sat_cnt0", 64'(gc0_s), 64'd3);
    check("lit_sat_stall", 64'(stc_s), 64'd2);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
